// File: rtl/half_adder.sv
// half_adder: registered unsigned adder with configurable latency, valid tracking and a saturating carry counter
module half_adder #(
  parameter int WIDTH = 2,
  parameter int LATENCY = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH:0]   sum,
  output logic             carry,
  output logic             out_valid,
  output logic [15:0]      carry_count
);
  logic [WIDTH:0]     d [LATENCY];
  logic [LATENCY-1:0] v;
  // data stages only load behind a valid bit, so the output holds its last valid result
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LATENCY; i++) d[i] <= '0;
      v <= '0;
      carry_count <= '0;
    end else begin
      v[0] <= in_valid;
      if (in_valid) d[0] <= {1'b0, a} + {1'b0, b};
      for (int i = 1; i < LATENCY; i++) begin
        v[i] <= v[i-1];
        if (v[i-1]) d[i] <= d[i-1];
      end
      if (out_valid && carry && carry_count != 16'hFFFF) carry_count <= carry_count + 16'd1;
    end
  end
  assign sum       = d[LATENCY-1];
  assign carry     = sum[WIDTH];
  assign out_valid = v[LATENCY-1];
endmodule

// File: tb/tb_half_adder.sv
// tb_half_adder: scoreboard bench driving a LATENCY=1 and a LATENCY=3 instance with shared stimulus
module tb_half_adder;
  localparam int W = 2;
  typedef struct { logic [W:0] s; int due; } ent_t;
  logic clk = 0, rst = 1, in_valid = 1;
  logic [W-1:0] a = 2'b11, b = 2'b11;
  logic [W:0] sum1, sum3;
  logic carry1, carry3, ov1, ov3;
  logic [15:0] cc1, cc3;
  int cyc = 0, pass_n = 0, total = 0;
  bit mon_on = 0;
  ent_t q1[$], q3[$];
  ent_t e1, e3;
  logic [W:0] last1 = '0, last3 = '0;
  logic [15:0] ccx1 = '0, ccx3 = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  half_adder #(.WIDTH(W), .LATENCY(1)) u1 (.clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b),
    .sum(sum1), .carry(carry1), .out_valid(ov1), .carry_count(cc1));
  half_adder #(.WIDTH(W), .LATENCY(3)) u3 (.clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b),
    .sum(sum3), .carry(carry3), .out_valid(ov3), .carry_count(cc3));

  // scoreboard monitor: every negedge, each output must match the queue head due this cycle
  always @(negedge clk) if (mon_on) begin
    automatic bit ev1 = q1.size() > 0 && q1[0].due == cyc;
    automatic bit ev3 = q3.size() > 0 && q3[0].due == cyc;
    total++; if (ov1 !== ev1) $display("FAIL mon1_valid cyc %0d got %b want %b", cyc, ov1, ev1); else pass_n++;
    total++; if (cc1 !== ccx1) $display("FAIL mon1_count cyc %0d got %0d want %0d", cyc, cc1, ccx1); else pass_n++;
    if (ev1) begin
      e1 = q1.pop_front();
      last1 = e1.s;
      if (e1.s[W] && ccx1 != 16'hFFFF) ccx1++;
    end
    total++; if ({carry1, sum1} !== {last1[W], last1}) $display("FAIL mon1_sum cyc %0d got %b/%b want %b", cyc, carry1, sum1, last1); else pass_n++;
    total++; if (ov3 !== ev3) $display("FAIL mon3_valid cyc %0d got %b want %b", cyc, ov3, ev3); else pass_n++;
    total++; if (cc3 !== ccx3) $display("FAIL mon3_count cyc %0d got %0d want %0d", cyc, cc3, ccx3); else pass_n++;
    if (ev3) begin
      e3 = q3.pop_front();
      last3 = e3.s;
      if (e3.s[W] && ccx3 != 16'hFFFF) ccx3++;
    end
    total++; if ({carry3, sum3} !== {last3[W], last3}) $display("FAIL mon3_sum cyc %0d got %b/%b want %b", cyc, carry3, sum3, last3); else pass_n++;
  end

  task automatic drive(input int r, input int v, input int x, input int y);
    logic [W:0] e;
    @(negedge clk); #1;
    rst = (r != 0); in_valid = (v != 0); a = W'(x); b = W'(y);
    e = {1'b0, a} + {1'b0, b};
    if (r != 0) begin
      q1.delete(); q3.delete();
      last1 = '0; last3 = '0; ccx1 = '0; ccx3 = '0;
    end else if (v != 0) begin
      q1.push_back('{e, cyc + 1});
      q3.push_back('{e, cyc + 3});
    end
  endtask

  task automatic test_reset;
    @(posedge clk); #1;
    mon_on = 1;
    for (int i = 0; i < 3; i++) begin
      drive(i == 0, i == 0, 3, 3);
      total++;
      if ({ov1, carry1, sum1, cc1, ov3, carry3, sum3, cc3} !== '0)
        $display("FAIL reset_%0d got %b%b%b %0d %b%b%b %0d want all zero", i, ov1, carry1, sum1, cc1, ov3, carry3, sum3, cc3);
      else pass_n++;
    end
  endtask

  task automatic test_add;
    drive(0, 1, 0, 3);
    drive(0, 1, 1, 3);
    total++; if ({ov1, carry1, sum1} !== 5'b10011) $display("FAIL add_0p3 got %b%b%b want 10011", ov1, carry1, sum1); else pass_n++;
    drive(0, 1, 1, 2);
    total++; if ({ov1, carry1, sum1} !== 5'b11100) $display("FAIL add_1p3 got %b%b%b want 11100", ov1, carry1, sum1); else pass_n++;
    drive(0, 0, 0, 0);
    total++; if ({ov1, carry1, sum1} !== 5'b10011) $display("FAIL add_1p2 got %b%b%b want 10011", ov1, carry1, sum1); else pass_n++;
    drive(0, 0, 0, 0);
    total++; if ({ov1, sum1, cc1} !== {1'b0, 3'b011, 16'd1}) $display("FAIL add_count got %b %b %0d want 0 011 1", ov1, sum1, cc1); else pass_n++;
  endtask

  task automatic test_extremes;
    drive(0, 1, 3, 3);
    drive(0, 1, 0, 0);
    total++; if ({ov1, carry1, sum1} !== 5'b11110) $display("FAIL ext_max got %b%b%b want 11110", ov1, carry1, sum1); else pass_n++;
    drive(0, 0, 0, 0);
    total++; if ({ov1, carry1, sum1} !== 5'b10000) $display("FAIL ext_zero got %b%b%b want 10000", ov1, carry1, sum1); else pass_n++;
  endtask

  task automatic test_gap;
    drive(0, 1, 2, 1);
    drive(0, 0, 1, 2);
    total++; if ({ov1, carry1, sum1} !== 5'b10011) $display("FAIL gap_valid got %b%b%b want 10011", ov1, carry1, sum1); else pass_n++;
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, i + 2, 3 - i);
      total++; if ({ov1, carry1, sum1} !== 5'b00011) $display("FAIL gap_hold_%0d got %b%b%b want 00011", i, ov1, carry1, sum1); else pass_n++;
    end
  endtask

  task automatic test_back_to_back;
    logic [W:0] es [4];
    es[0] = 3'd3; es[1] = 3'd6; es[2] = 3'd1; es[3] = 3'd5;
    repeat (4) drive(0, 0, 0, 0);
    for (int j = 1; j <= 8; j++) begin
      case (j)
        1: drive(0, 1, 1, 2);
        2: drive(0, 1, 3, 3);
        3: drive(0, 1, 0, 1);
        4: drive(0, 1, 2, 3);
        default: drive(0, 0, j, j + 1);
      endcase
      total++;
      if (j >= 4 && j <= 7) begin
        if ({ov3, sum3} !== {1'b1, es[j-4]}) $display("FAIL b2b_out_%0d got %b %b want 1 %b", j, ov3, sum3, es[j-4]); else pass_n++;
      end else if (ov3 !== 1'b0) $display("FAIL b2b_idle_%0d got %b want 0", j, ov3); else pass_n++;
    end
  endtask

  task automatic test_midstream_reset;
    for (int k = 0; k < 11; k++) begin
      case (k)
        0: drive(0, 1, 3, 3);
        1: drive(0, 1, 2, 2);
        2: drive(1, 1, 1, 1);
        5: drive(0, 1, 1, 2);
        default: drive(0, 0, k, k + 2);
      endcase
      if (k == 3) begin
        total++; if ({ov3, sum3, cc3} !== '0) $display("FAIL mid_flush got %b %b %0d want 0 000 0", ov3, sum3, cc3); else pass_n++;
      end else if (k == 8) begin
        total++; if ({ov3, carry3, sum3} !== 5'b10011) $display("FAIL mid_first got %b%b%b want 10011", ov3, carry3, sum3); else pass_n++;
      end else if (k > 0) begin
        total++; if (ov3 !== 1'b0) $display("FAIL mid_idle_%0d got %b want 0", k, ov3); else pass_n++;
      end
    end
  endtask

  initial begin
    test_reset;
    test_add;
    test_extremes;
    test_gap;
    test_back_to_back;
    test_midstream_reset;
    repeat (4) drive(0, 0, 0, 0);
    $display("%0d/%0d checks passed", pass_n, total);
    $finish;
  end
endmodule
